// File: rtl/jt51_dac_pkg.sv
// Field layout of the YM3012-format serial channel word shared by the
// JT51 DAC receiver and its decoder.
package jt51_dac_pkg;

  localparam int PAD_BITS  = 3;
  localparam int MAN_BITS  = 10;
  localparam int EXP_BITS  = 3;
  localparam int WORD_BITS = PAD_BITS + MAN_BITS + EXP_BITS;

  // LSB positions of each field inside the receive shift register.
  localparam int PAD_LSB = 0;
  localparam int MAN_LSB = PAD_LSB + PAD_BITS;
  localparam int EXP_LSB = MAN_LSB + MAN_BITS;

endpackage

// File: rtl/jt51_exp2lin.sv
// Floating-point to linear converter: 10-bit signed mantissa plus 3-bit
// exponent back to a signed 16-bit sample. exp=0 means silence, exp=n
// scales the sign-extended mantissa by 2^(n-1). The largest case
// (exp=7) still fits 16 bits, so no saturation is required.
module jt51_exp2lin
  import jt51_dac_pkg::*;
(
  input  logic [MAN_BITS-1:0] man,
  input  logic [EXP_BITS-1:0] exp,
  output logic [15:0]         lin
);

  logic [15:0] man_ext;

  assign man_ext = {{(16-MAN_BITS){man[MAN_BITS-1]}}, man};

  // Shift the sign-extended mantissa into place; zero exponent is silence.
  always_comb begin
    lin = '0;
    if (exp != '0) begin
      lin = man_ext << (exp - 3'd1);
    end
  end

endmodule

// File: rtl/jt51_dac_rx.sv
// YM3012-format serial DAC receiver. Shifts `so` in LSB first on every
// `cen`, and on a falling edge of sh1 (left) or sh2 (right) latches the
// decoded 16 bits received before that cycle into the matching output.
// `sample` pulses for one clk whenever `right` updates.
//
// Optional feature macro: JT51_DAC_RX_ERRCHK_EN
//   When defined, a word closed while synced with a length other than
//   WORD_BITS, or a simultaneous sh1/sh2 fall, pulses `frame_err` and the
//   affected output keeps its old value. When undefined, every word is
//   latched and `frame_err` is tied low.
//
// Handshake: there is no ready path. A bit is consumed on every clk
// edge with cen=1; strobes are edge-detected against their value
// registered on the previous cen cycle; outputs change only on cen edges.
module jt51_dac_rx
  import jt51_dac_pkg::*;
#(
  parameter int WORD_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        so,
  input  logic        sh1,
  input  logic        sh2,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic        sample,
  output logic        frame_err
);

  logic [WORD_BITS-1:0] sr;
  logic                 sh1_q;
  logic                 sh2_q;
  logic                 fall1;
  logic                 fall2;
  logic                 take1;
  logic                 take2;
  logic [15:0]          dec_l;
  logic [15:0]          dec_r;
  logic                 unused_pad;

  assign fall1 = cen & sh1_q & ~sh1;
  assign fall2 = cen & sh2_q & ~sh2;

  // Pad slots carry no information.
  assign unused_pad = ^sr[PAD_LSB +: PAD_BITS];

  // Both channels decode the same pre-shift word; only the latch differs.
  jt51_exp2lin u_dec_l (
    .man (sr[MAN_LSB +: MAN_BITS]),
    .exp (sr[EXP_LSB +: EXP_BITS]),
    .lin (dec_l)
  );

  jt51_exp2lin u_dec_r (
    .man (sr[MAN_LSB +: MAN_BITS]),
    .exp (sr[EXP_LSB +: EXP_BITS]),
    .lin (dec_r)
  );

`ifdef JT51_DAC_RX_ERRCHK_EN
  logic [4:0] bcnt;
  logic       synced;
  logic       bad1;
  logic       bad2;

  // Reject short/long words once synced, and any simultaneous strobe fall.
  always_comb begin
    bad1  = 1'b0;
    bad2  = 1'b0;
    take1 = fall1;
    take2 = fall2;
    if (fall1 && fall2) begin
      bad1 = 1'b1;
      bad2 = 1'b1;
    end else begin
      bad1 = fall1 & synced & (bcnt != 5'(WORD_BITS));
      bad2 = fall2 & synced & (bcnt != 5'(WORD_BITS));
    end
    take1 = fall1 & ~bad1;
    take2 = fall2 & ~bad2;
  end

  // Word-length counter, sync flag and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt      <= '0;
      synced    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (cen) begin
        if (fall1 || fall2) begin
          bcnt      <= 5'd1;
          synced    <= 1'b1;
          frame_err <= bad1 | bad2;
        end else if (bcnt != 5'd31) begin
          bcnt <= bcnt + 5'd1;
        end
      end
    end
  end
`else
  // Every closed word is accepted.
  always_comb begin
    take1 = fall1;
    take2 = fall2;
  end

  assign frame_err = 1'b0;
`endif

  // Shift register, strobe history, output latches and sample pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr     <= '0;
      sh1_q  <= 1'b0;
      sh2_q  <= 1'b0;
      left   <= '0;
      right  <= '0;
      sample <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (cen) begin
        sr    <= {so, sr[WORD_BITS-1:1]};
        sh1_q <= sh1;
        sh2_q <= sh2;
        if (take1) begin
          left <= dec_l;
        end
        if (take2) begin
          right  <= dec_r;
          sample <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt51_dac_rx.sv
// Directed bench for jt51_dac_rx: a table of stereo frames with
// hand-computed decoded values, plus sequences for short words,
// simultaneous strobes and mid-word reset. Honours JT51_DAC_RX_ERRCHK_EN.
module tb_jt51_dac_rx;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic        so;
  logic        sh1;
  logic        sh2;
  logic [15:0] left;
  logic [15:0] right;
  logic        sample;
  logic        frame_err;

  int checks;
  int errors;
  int sample_cnt;
  int err_cnt;
  int wide_cnt;

  typedef struct {
    logic [2:0]  le;
    logic [9:0]  lm;
    logic [2:0]  re;
    logic [9:0]  rm;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } frame_t;

  frame_t vecs[7];

  jt51_dac_rx #(.WORD_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .so        (so),
    .sh1       (sh1),
    .sh2       (sh2),
    .left      (left),
    .right     (right),
    .sample    (sample),
    .frame_err (frame_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [2:0] e, input logic [9:0] m);
    logic [2:0] pad;
    pad = 3'($urandom_range(0, 7));
    return {e, m, pad};
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One serial bit on a cen cycle followed by an idle cycle; counts pulses.
  task automatic bit_cycle(input logic b, input logic s1, input logic s2);
    @(negedge clk);
    so  = b;
    sh1 = s1;
    sh2 = s2;
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    sample_cnt += int'(sample);
    err_cnt    += int'(frame_err);
    @(negedge clk);
    if (sample || frame_err) wide_cnt++;
  endtask

  // Send n bits of w starting at bit lo, LSB first, with fixed strobe levels.
  task automatic send_bits(input logic [15:0] w, input int lo, input int n,
                           input logic s1, input logic s2);
    sample_cnt = 0;
    err_cnt    = 0;
    for (int i = lo; i < lo + n; i++) begin
      bit_cycle(w[i], s1, s2);
    end
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] prev_l;
    logic [15:0] prev_r;

    checks   = 0;
    errors   = 0;
    wide_cnt = 0;
    sample_cnt = 0;
    err_cnt  = 0;

    //                le    lm       re    rm       exp_l     exp_r
    vecs[0] = '{3'd7, 10'h1FF, 3'd1, 10'h200, 16'h7FC0, 16'hFE00};
    vecs[1] = '{3'd0, 10'h155, 3'd4, 10'h001, 16'h0000, 16'h0008};
    vecs[2] = '{3'd7, 10'h1FF, 3'd7, 10'h200, 16'h7FC0, 16'h8000}; // +/-32767 quantised
    vecs[3] = '{3'd1, 10'h001, 3'd1, 10'h3FF, 16'h0001, 16'hFFFF}; // +/-1
    vecs[4] = '{3'd2, 10'h2AB, 3'd1, 10'h000, 16'hFD56, 16'h0000}; // 0
    vecs[5] = '{3'd5, 10'h0F0, 3'd6, 10'h3FF, 16'h0F00, 16'hFFE0};
    vecs[6] = '{3'd3, 10'h100, 3'd0, 10'h3FF, 16'h0400, 16'h0000};

    // Reset
    rst_n = 1'b0;
    cen   = 1'b0;
    so    = 1'b0;
    sh1   = 1'b0;
    sh2   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check16("reset_left", left, 16'h0000);
    check16("reset_right", right, 16'h0000);
    check_int("reset_sample", int'(sample), 0);
    check_int("reset_frame_err", int'(frame_err), 0);

    // Table of stereo frames: left word with sh1 high, right word with sh2 high.
    prev_l = 16'h0000;
    prev_r = 16'h0000;
    for (int k = 0; k < 7; k++) begin
      send_bits(mk(vecs[k].le, vecs[k].lm), 0, 16, 1'b1, 1'b0);
      check16($sformatf("f%0d_right_on_sh2_fall", k), right, prev_r);
      check_int($sformatf("f%0d_sample_cnt_l", k), sample_cnt, (k > 0) ? 1 : 0);
      check_int($sformatf("f%0d_err_l", k), err_cnt, 0);
      check16($sformatf("f%0d_left_hold", k), left, prev_l);

      send_bits(mk(vecs[k].re, vecs[k].rm), 0, 16, 1'b0, 1'b1);
      check16($sformatf("f%0d_left", k), left, vecs[k].exp_l);
      check_int($sformatf("f%0d_sample_cnt_r", k), sample_cnt, 0);
      check_int($sformatf("f%0d_err_r", k), err_cnt, 0);
      check16($sformatf("f%0d_right_hold", k), right, prev_r);
      prev_l = vecs[k].exp_l;
      prev_r = vecs[k].exp_r;
    end
    // Close the final right word.
    send_bits(16'h0000, 0, 1, 1'b0, 1'b0);
    check16("last_right", right, prev_r);
    check_int("last_sample", sample_cnt, 1);

    // Short left word: fall after 15 bits of zeros.
    send_bits(16'h0000, 0, 14, 1'b1, 1'b0);
    w = mk(3'd4, 10'h001);
    send_bits(w, 0, 1, 1'b0, 1'b0);
`ifdef JT51_DAC_RX_ERRCHK_EN
    check_int("short_err", err_cnt, 1);
    check16("short_left_hold", left, 16'h0400);
`else
    check_int("short_err", err_cnt, 0);
    check16("short_left_latched", left, 16'h0000);
`endif
    check_int("short_sample", sample_cnt, 0);
    // Next correct word: its bit 0 went in on the error fall cycle.
    send_bits(w, 1, 15, 1'b1, 1'b0);
    send_bits(16'h0000, 0, 1, 1'b0, 1'b0);
    check16("recover_left", left, 16'h0008);
    check_int("recover_err", err_cnt, 0);
    prev_l = 16'h0008;

    // Simultaneous sh1/sh2 fall.
    send_bits(mk(3'd7, 10'h1FF), 0, 16, 1'b1, 1'b1);
    send_bits(16'h0000, 0, 1, 1'b0, 1'b0);
`ifdef JT51_DAC_RX_ERRCHK_EN
    check16("both_left", left, prev_l);
    check16("both_right", right, prev_r);
    check_int("both_err", err_cnt, 1);
    check_int("both_sample", sample_cnt, 0);
`else
    check16("both_left", left, 16'h7FC0);
    check16("both_right", right, 16'h7FC0);
    check_int("both_err", err_cnt, 0);
    check_int("both_sample", sample_cnt, 1);
`endif

    // Reset eight bits into a right word.
    send_bits(16'hA5C3, 0, 8, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check16("midrst_left", left, 16'h0000);
    check16("midrst_right", right, 16'h0000);
    check_int("midrst_sample", int'(sample), 0);
    check_int("midrst_frame_err", int'(frame_err), 0);
    // Partial word, then the first sh2 fall only syncs.
    send_bits(16'h0000, 0, 5, 1'b0, 1'b1);
    send_bits(mk(3'd7, 10'h1FF), 0, 16, 1'b1, 1'b0);
    check_int("sync_err", err_cnt, 0);
    check_int("sync_sample", sample_cnt, 1);
    check16("sync_right", right, 16'h0000);
    send_bits(mk(3'd1, 10'h200), 0, 16, 1'b0, 1'b1);
    check16("post_rst_left", left, 16'h7FC0);
    check_int("post_rst_err_l", err_cnt, 0);
    send_bits(16'h0000, 0, 1, 1'b0, 1'b0);
    check16("post_rst_right", right, 16'hFE00);
    check_int("post_rst_sample", sample_cnt, 1);
    check_int("post_rst_err_r", err_cnt, 0);

    check_int("pulse_width", wide_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
